// File: rtl/level_flow_ctrl.sv
// level_flow_ctrl: frame-aligned level/game progress controller for the black-screen overlay.
// Ports: clk, reset (async, active high), startOfFrame/birdLanded/pigHit/restart pulses,
// skipLevel (only with LEVEL_SKIP_EN), levelChange/GAMEOVER/gameWon flags,
// level, birdsLeft, pigsLeft counts. Optional feature macro: LEVEL_SKIP_EN.
module level_flow_ctrl #(
    parameter int NUM_LEVELS      = 3,
    parameter int BIRDS_PER_LEVEL = 3,
    parameter int PIGS_PER_LEVEL  = 2,
    parameter int SETTLE_FRAMES   = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       birdLanded,
    input  logic       pigHit,
    input  logic       restart,
`ifdef LEVEL_SKIP_EN
    input  logic       skipLevel,
`endif
    output logic       levelChange,
    output logic       GAMEOVER,
    output logic       gameWon,
    output logic [1:0] level,
    output logic [2:0] birdsLeft,
    output logic [2:0] pigsLeft
);
    localparam int CW = SETTLE_FRAMES > 0 ? $clog2(SETTLE_FRAMES + 1) : 1;
    localparam logic [1:0]    LAST   = 2'(NUM_LEVELS - 1);
    localparam logic [2:0]    BIRDS  = 3'(BIRDS_PER_LEVEL);
    localparam logic [2:0]    PIGS   = 3'(PIGS_PER_LEVEL);
    localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE_FRAMES);

    typedef enum logic [2:0] {PLAY, SETTLE, CHANGE, OVER, WON} state_t;

    state_t        state_q, state_d;
    logic [1:0]    level_q, level_d;
    logic [2:0]    birds_q, birds_d, pigs_q, pigs_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lc_q, lc_d, go_q, go_d, won_q, won_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PLAY;
            level_q <= '0;
            birds_q <= BIRDS;
            pigs_q  <= PIGS;
            cnt_q   <= '0;
            lc_q    <= 1'b0;
            go_q    <= 1'b0;
            won_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            birds_q <= birds_d;
            pigs_q  <= pigs_d;
            cnt_q   <= cnt_d;
            lc_q    <= lc_d;
            go_q    <= go_d;
            won_q   <= won_d;
        end
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        birds_d = birds_q;
        pigs_d  = pigs_q;
        cnt_d   = cnt_q;
        lc_d    = lc_q;
        go_d    = go_q;
        won_d   = won_q;
        if (restart) begin
            state_d = PLAY;
            level_d = '0;
            birds_d = BIRDS;
            pigs_d  = PIGS;
            cnt_d   = '0;
            lc_d    = 1'b0;
            go_d    = 1'b0;
            won_d   = 1'b0;
        end else begin
            case (state_q)
                PLAY: begin
                    birds_d = (birdLanded && birds_q != '0) ? birds_q - 3'd1 : birds_q;
                    pigs_d  = (pigHit && pigs_q != '0) ? pigs_q - 3'd1 : pigs_q;
`ifdef LEVEL_SKIP_EN
                    pigs_d  = skipLevel ? '0 : pigs_d;
`endif
                    // decisions use the registered counts, so a pig reaching 0 wins over a bird reaching 0
                    if (pigs_q == '0) begin
                        state_d = SETTLE;
                        cnt_d   = SETTLE_C;
                    end else if (birds_q == '0) begin
                        state_d = OVER;
                        go_d    = 1'b1;
                    end
                end
                SETTLE: begin
                    if (startOfFrame) begin
                        if (cnt_q != '0) begin
                            cnt_d = cnt_q - 1'b1;
                        end else if (level_q < LAST) begin
                            state_d = CHANGE;
                            lc_d    = 1'b1;
                        end else begin
                            state_d = WON;
                            won_d   = 1'b1;
                        end
                    end
                end
                CHANGE: begin
                    if (startOfFrame) begin
                        state_d = PLAY;
                        lc_d    = 1'b0;
                        level_d = level_q + 2'd1;
                        birds_d = BIRDS;
                        pigs_d  = PIGS;
                    end
                end
                default: ;
            endcase
        end
    end

    assign levelChange = lc_q;
    assign GAMEOVER    = go_q;
    assign gameWon     = won_q;
    assign level       = level_q;
    assign birdsLeft   = birds_q;
    assign pigsLeft    = pigs_q;
endmodule

// File: tb/tb_level_flow_ctrl.sv
// tb_level_flow_ctrl: directed self-checking bench for level_flow_ctrl.
module tb_level_flow_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sof = 1'b0, bird = 1'b0, pig = 1'b0, rs = 1'b0;
    logic       skip = 1'b0;
    logic       lc, go, won;
    logic [1:0] level;
    logic [2:0] birds, pigs;
    int         n_chk = 0, n_fail = 0;

    level_flow_ctrl #(.SETTLE_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .startOfFrame(sof), .birdLanded(bird),
        .pigHit(pig), .restart(rs),
`ifdef LEVEL_SKIP_EN
        .skipLevel(skip),
`endif
        .levelChange(lc), .GAMEOVER(go), .gameWon(won),
        .level(level), .birdsLeft(birds), .pigsLeft(pigs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic drive(input logic p, input logic b, input logic r);
        @(negedge clk);
        pig = p; bird = b; rs = r;
        @(negedge clk);
        pig = 1'b0; bird = 1'b0; rs = 1'b0;
    endtask

    task automatic frame();
        @(negedge clk);
        sof = 1'b1;
        @(negedge clk);
        sof = 1'b0;
    endtask

    task automatic finish_level();
        drive(1, 0, 0);
        drive(1, 0, 0);
        repeat (4) frame();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_level"}, level, 0);
        chk({tag, "_birds"}, birds, 3);
        chk({tag, "_pigs"}, pigs, 2);
        chk({tag, "_lc"}, lc, 0);
        chk({tag, "_go"}, go, 0);
        chk({tag, "_won"}, won, 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("rst");

        drive(1, 0, 0);
        chk("pig_2to1", pigs, 1);
        drive(1, 0, 0);
        chk("pig_1to0", pigs, 0);
        drive(1, 0, 0);
        chk("pig_sat0", pigs, 0);
        frame();
        chk("lc_f1", lc, 0);
        frame();
        chk("lc_f2", lc, 0);
        frame();
        chk("lc_f3_rise", lc, 1);
        chk("lvl_in_change", level, 0);
        frame();
        chk("lc_f4_fall", lc, 0);
        chk("lvl_adv", level, 1);
        chk("birds_reload", birds, 3);
        chk("pigs_reload", pigs, 2);

        drive(1, 0, 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        chk("birds_zero", birds, 0);
        chk("go_not_yet", go, 0);
        @(negedge clk);
        chk("go_set", go, 1);
        drive(1, 0, 0);
        chk("pig_ignored_over", pigs, 1);
        chk("go_sticky", go, 1);
        chk("won_not_go", won, 0);
        drive(0, 0, 1);
        chk_reset_vals("restart");

        finish_level();
        finish_level();
        chk("lvl_last", level, 2);
        drive(1, 0, 0);
        drive(0, 1, 0);
        drive(0, 1, 0);
        drive(1, 1, 0);
        chk("simul_pigs", pigs, 0);
        chk("simul_birds", birds, 0);
        @(negedge clk);
        chk("simul_no_go", go, 0);
        repeat (3) frame();
        chk("won_set", won, 1);
        chk("won_go_clear", go, 0);
        chk("won_lc", lc, 0);
        drive(0, 0, 1);
        chk("won_restart", won, 0);

        finish_level();
        drive(1, 0, 0);
        drive(1, 0, 0);
        repeat (3) frame();
        chk("chg_lc", lc, 1);
        chk("chg_level", level, 1);
        drive(0, 0, 1);
        chk("rs_chg_lc", lc, 0);
        chk("rs_chg_level", level, 0);

        finish_level();
        drive(1, 0, 0);
        drive(1, 0, 0);
        frame();
        #2 reset = 1'b1;
        #1 chk_reset_vals("async");
        @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("async_rel");

`ifdef LEVEL_SKIP_EN
        @(negedge clk);
        skip = 1'b1;
        @(negedge clk);
        skip = 1'b0;
        chk("skip_pigs", pigs, 0);
        repeat (4) frame();
        chk("skip_level", level, 1);
        chk("skip_pigs_reload", pigs, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
